// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences single accesses onto the shared memory bus.
// Requests are latched at grant; reads wait out LAT cycles and return data with a one-cycle Ack.
module mem_arbiter #(
  parameter int M   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0Req,
  input  logic         p0WE,
  input  logic [M-1:0] p0Addr,
  input  logic [M-1:0] p0WData,
  output logic         p0Ack,
  output logic [M-1:0] p0RData,
  input  logic         p1Req,
  input  logic         p1WE,
  input  logic [M-1:0] p1Addr,
  input  logic [M-1:0] p1WData,
  output logic         p1Ack,
  output logic [M-1:0] p1RData,
  output logic [M-1:0] memAddr,
  output logic [M-1:0] memWrite,
  output logic         memWE,
  input  logic [M-1:0] memRead,
  output logic         grant,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_t     state;
  state_t     stateNext;
  logic       lastGnt;
  logic       curWE;
  logic [2:0] latCnt;
  logic       elig0;
  logic       elig1;
  logic       gntValid;
  logic       gntPort;
  logic       gntWE;
  logic       accessDone;

  // The port being acknowledged sits out the back-to-back grant so the other port cannot starve.
  always_comb begin
    elig0      = p0Req && !(state == ACK && grant == 1'b0);
    elig1      = p1Req && !(state == ACK && grant == 1'b1);
    gntValid   = (state != ACCESS) && (elig0 || elig1);
    gntPort    = (elig0 && elig1) ? ~lastGnt : elig1;
    gntWE      = gntPort ? p1WE : p0WE;
    accessDone = (state == ACCESS) && (latCnt == 3'd0);
    stateNext  = state;
    unique case (state)
      IDLE:    if (gntValid) stateNext = ACCESS;
      ACCESS:  if (accessDone) stateNext = ACK;
      ACK:     stateNext = gntValid ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lastGnt  <= 1'b1;
      grant    <= 1'b0;
      busy     <= 1'b0;
      curWE    <= 1'b0;
      latCnt   <= 3'd0;
      memAddr  <= '0;
      memWrite <= '0;
      memWE    <= 1'b0;
      p0Ack    <= 1'b0;
      p1Ack    <= 1'b0;
      p0RData  <= '0;
      p1RData  <= '0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE);
      p0Ack <= accessDone && !grant;
      p1Ack <= accessDone && grant;
      memWE <= 1'b0;
      if (gntValid) begin
        grant    <= gntPort;
        lastGnt  <= gntPort;
        curWE    <= gntWE;
        memAddr  <= gntPort ? p1Addr : p0Addr;
        memWrite <= gntPort ? p1WData : p0WData;
        memWE    <= gntWE;
        latCnt   <= gntWE ? 3'd0 : LAT_CNT;
      end else if (state == ACCESS && !accessDone) begin
        latCnt <= latCnt - 3'd1;
      end else begin
        memAddr  <= '0;
        memWrite <= '0;
        // Read data is sampled on the final ACCESS cycle, when memory has had LAT cycles.
        if (accessDone && !curWE) begin
          if (grant) p1RData <= memRead;
          else       p0RData <= memRead;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 0, 1, 3) share the request inputs; each has its
// own memory model whose read data appears exactly LAT cycles after the address.
module tb_mem_arbiter;

  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         p0Req, p0WE, p1Req, p1WE;
  logic [M-1:0] p0Addr, p0WData, p1Addr, p1WData;
  logic         p0Ack [3];
  logic         p1Ack [3];
  logic         memWE [3];
  logic         grant [3];
  logic         busy [3];
  logic [M-1:0] p0RData [3];
  logic [M-1:0] p1RData [3];
  logic [M-1:0] memAddr [3];
  logic [M-1:0] memWrite [3];
  logic [M-1:0] memRead [3];
  logic [M-1:0] pipe1, pipe3a, pipe3b, pipe3c;
  int           nPass = 0;
  int           nTotal = 0;

  always #5 clk = ~clk;

  function automatic logic [M-1:0] memFn(input logic [M-1:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    pipe1  <= memAddr[1];
    pipe3a <= memAddr[2];
    pipe3b <= pipe3a;
    pipe3c <= pipe3b;
  end

  always_comb begin
    memRead[0] = memFn(memAddr[0]);
    memRead[1] = memFn(pipe1);
    memRead[2] = memFn(pipe3c);
  end

  mem_arbiter #(.M(M), .LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .p0Req(p0Req), .p0WE(p0WE), .p0Addr(p0Addr), .p0WData(p0WData), .p0Ack(p0Ack[0]), .p0RData(p0RData[0]),
    .p1Req(p1Req), .p1WE(p1WE), .p1Addr(p1Addr), .p1WData(p1WData), .p1Ack(p1Ack[0]), .p1RData(p1RData[0]),
    .memAddr(memAddr[0]), .memWrite(memWrite[0]), .memWE(memWE[0]), .memRead(memRead[0]),
    .grant(grant[0]), .busy(busy[0])
  );

  mem_arbiter #(.M(M), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .p0Req(p0Req), .p0WE(p0WE), .p0Addr(p0Addr), .p0WData(p0WData), .p0Ack(p0Ack[1]), .p0RData(p0RData[1]),
    .p1Req(p1Req), .p1WE(p1WE), .p1Addr(p1Addr), .p1WData(p1WData), .p1Ack(p1Ack[1]), .p1RData(p1RData[1]),
    .memAddr(memAddr[1]), .memWrite(memWrite[1]), .memWE(memWE[1]), .memRead(memRead[1]),
    .grant(grant[1]), .busy(busy[1])
  );

  mem_arbiter #(.M(M), .LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0Req(p0Req), .p0WE(p0WE), .p0Addr(p0Addr), .p0WData(p0WData), .p0Ack(p0Ack[2]), .p0RData(p0RData[2]),
    .p1Req(p1Req), .p1WE(p1WE), .p1Addr(p1Addr), .p1WData(p1WData), .p1Ack(p1Ack[2]), .p1RData(p1RData[2]),
    .memAddr(memAddr[2]), .memWrite(memWrite[2]), .memWE(memWE[2]), .memRead(memRead[2]),
    .grant(grant[2]), .busy(busy[2])
  );

  task automatic clearInputs();
    p0Req = 1'b0; p0WE = 1'b0; p0Addr = '0; p0WData = '0;
    p1Req = 1'b0; p1WE = 1'b0; p1Addr = '0; p1WData = '0;
  endtask

  // Leaves the bench at a falling edge with all instances idle; next inputs are sampled at edge 0.
  task automatic applyReset();
    clearInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nTotal++;
    if ({busy[1], grant[1], p0Ack[1], p1Ack[1], memWE[1]} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy[1], grant[1], p0Ack[1], p1Ack[1], memWE[1]});
    else nPass++;
    rst = 1'b1;
    @(negedge clk);
    p1Req = 1'b1; p1WE = 1'b0; p1Addr = 16'h0066;
    repeat (3) @(negedge clk);
    nTotal++;
    if (p1Ack[1] !== 1'b1 || p1RData[1] !== memFn(16'h0066))
      $display("FAIL reset_preread: ack %b data %h want 1 %h", p1Ack[1], p1RData[1], memFn(16'h0066));
    else nPass++;
    p1Addr = 16'h0077;
    repeat (2) @(negedge clk);
    nTotal++;
    if (busy[1] !== 1'b1 || memAddr[1] !== 16'h0077)
      $display("FAIL reset_inaccess: busy %b addr %h want 1 0077", busy[1], memAddr[1]);
    else nPass++;
    #2 rst = 1'b0;
    #1;
    nTotal++;
    if ({busy[1], grant[1], p0Ack[1], p1Ack[1], memWE[1]} !== 5'b0)
      $display("FAIL reset_async_ctrl: got %b want 00000", {busy[1], grant[1], p0Ack[1], p1Ack[1], memWE[1]});
    else nPass++;
    nTotal++;
    if ({memAddr[1], memWrite[1], p0RData[1], p1RData[1]} !== 64'h0)
      $display("FAIL reset_async_data: got %h want 0", {memAddr[1], memWrite[1], p0RData[1], p1RData[1]});
    else nPass++;
    p1Req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nTotal++;
      if (p1Ack[1] !== 1'b0 || busy[1] !== 1'b0)
        $display("FAIL reset_noack c%0d: ack %b busy %b want 0 0", c, p1Ack[1], busy[1]);
      else nPass++;
    end
  endtask

  task automatic test_single_read();
    applyReset();
    p0Req = 1'b1; p0WE = 1'b0; p0Addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) p0Req = 1'b0;
      nTotal++;
      if (memAddr[1] !== ((c <= 2) ? 16'h0010 : 16'h0000) || memWE[1] !== 1'b0)
        $display("FAIL read_addr c%0d: addr %h we %b", c, memAddr[1], memWE[1]);
      else nPass++;
      nTotal++;
      if (p0Ack[1] !== (c == 3) || busy[1] !== (c <= 3) || p1Ack[1] !== 1'b0)
        $display("FAIL read_ack c%0d: ack %b busy %b want %b %b", c, p0Ack[1], busy[1], c == 3, c <= 3);
      else nPass++;
    end
    nTotal++;
    if (p0RData[1] !== 16'hBEEF || p1RData[1] !== 16'h0000)
      $display("FAIL read_data: p0 %h p1 %h want beef 0000", p0RData[1], p1RData[1]);
    else nPass++;
  endtask

  task automatic test_single_write();
    applyReset();
    p1Req = 1'b1; p1WE = 1'b1; p1Addr = 16'h0200; p1WData = 16'h1234;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) p1Req = 1'b0;
      nTotal++;
      if ({memWE[1], memAddr[1], memWrite[1]} !== ((c == 1) ? {1'b1, 16'h0200, 16'h1234} : 33'h0))
        $display("FAIL write_bus c%0d: we %b addr %h data %h", c, memWE[1], memAddr[1], memWrite[1]);
      else nPass++;
      nTotal++;
      if (p1Ack[1] !== (c == 2) || p0Ack[1] !== 1'b0 || (c <= 2 && grant[1] !== 1'b1))
        $display("FAIL write_ack c%0d: ack %b grant %b want %b 1", c, p1Ack[1], grant[1], c == 2);
      else nPass++;
    end
  endtask

  task automatic test_simultaneous();
    applyReset();
    p0Req = 1'b1; p0WE = 1'b0; p0Addr = 16'h0021;
    p1Req = 1'b1; p1WE = 1'b0; p1Addr = 16'h0042;
    for (int c = 1; c <= 12; c++) begin
      logic expPort, expAck;
      @(negedge clk);
      expPort = 1'(((c - 1) / 3) % 2);
      expAck  = (c % 3 == 0);
      nTotal++;
      if ({busy[1], grant[1], p0Ack[1], p1Ack[1]} !== {1'b1, expPort, expAck && !expPort, expAck && expPort})
        $display("FAIL rr c%0d: busy/grant/ack0/ack1 %b want %b", c, {busy[1], grant[1], p0Ack[1], p1Ack[1]},
                 {1'b1, expPort, expAck && !expPort, expAck && expPort});
      else nPass++;
      if (expAck) begin
        nTotal++;
        if ((expPort ? p1RData[1] : p0RData[1]) !== memFn(expPort ? 16'h0042 : 16'h0021))
          $display("FAIL rr_data c%0d: got %h", c, expPort ? p1RData[1] : p0RData[1]);
        else nPass++;
      end
    end
    clearInputs();
  endtask

  task automatic test_lat_sweep();
    applyReset();
    p0Req = 1'b1; p0WE = 1'b0; p0Addr = 16'h0033;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      nTotal++;
      if (p0Ack[0] !== (c == 2) || (c == 2 && p0RData[0] !== memFn(16'h0033)))
        $display("FAIL lat0 c%0d: ack %b data %h want %b %h", c, p0Ack[0], p0RData[0], c == 2, memFn(16'h0033));
      else nPass++;
      nTotal++;
      if (p0Ack[2] !== (c == 5) || (c == 5 && p0RData[2] !== memFn(16'h0033)))
        $display("FAIL lat3 c%0d: ack %b data %h want %b %h", c, p0Ack[2], p0RData[2], c == 5, memFn(16'h0033));
      else nPass++;
      nTotal++;
      if (memAddr[2] !== ((c <= 4) ? 16'h0033 : 16'h0000) || (c <= 2 && memAddr[0] !== ((c == 1) ? 16'h0033 : 16'h0000)))
        $display("FAIL lat_addr c%0d: lat3 %h lat0 %h", c, memAddr[2], memAddr[0]);
      else nPass++;
      if (c == 1) begin
        p0Addr = 16'hFFFF;
        p0Req  = 1'b0;
      end
    end
  endtask

  task automatic test_dropped_req();
    applyReset();
    p0Req = 1'b1; p0WE = 1'b1; p0Addr = 16'h0055; p0WData = 16'hA5A5;
    @(negedge clk);
    p0Req = 1'b0;
    nTotal++;
    if ({memWE[1], memAddr[1], memWrite[1]} !== {1'b1, 16'h0055, 16'hA5A5})
      $display("FAIL drop_write: we %b addr %h data %h", memWE[1], memAddr[1], memWrite[1]);
    else nPass++;
    @(negedge clk);
    nTotal++;
    if (p0Ack[1] !== 1'b1 || memWE[1] !== 1'b0)
      $display("FAIL drop_ack: ack %b we %b want 1 0", p0Ack[1], memWE[1]);
    else nPass++;
    @(negedge clk);
    nTotal++;
    if (p0Ack[1] !== 1'b0 || busy[1] !== 1'b0)
      $display("FAIL drop_idle: ack %b busy %b want 0 0", p0Ack[1], busy[1]);
    else nPass++;
  endtask

  // Transaction-level reference for the LAT=1 instance: grant edge, port and end cycle per access.
  task automatic test_random();
    logic         req [2];
    logic         we [2];
    logic [M-1:0] addr [2];
    logic [M-1:0] wdata [2];
    logic [M-1:0] lastR [2];
    logic         act, cWE, ackNow, inAcc, e0, e1;
    logic [M-1:0] cAddr, cWData, expR0, expR1;
    int           curPort, lastG, gEdge, curEnd;
    applyReset();
    act = 1'b0; cWE = 1'b0; cAddr = '0; cWData = '0;
    curPort = 0; lastG = 1; gEdge = 0; curEnd = 0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; lastR[p] = '0;
    end
    for (int it = 0; it < 600; it++) begin
      ackNow = act && (it == curEnd);
      inAcc  = act && (it > gEdge) && (it < curEnd);
      expR0  = (ackNow && curPort == 0 && !cWE) ? memFn(cAddr) : lastR[0];
      expR1  = (ackNow && curPort == 1 && !cWE) ? memFn(cAddr) : lastR[1];
      nTotal++;
      if ({busy[1], p0Ack[1], p1Ack[1], memWE[1]} !==
          {act, ackNow && curPort == 0, ackNow && curPort == 1, inAcc && cWE && it == gEdge + 1})
        $display("FAIL rand_ctrl t%0d: busy/ack0/ack1/we %b", it, {busy[1], p0Ack[1], p1Ack[1], memWE[1]});
      else nPass++;
      if (act) begin
        nTotal++;
        if (grant[1] !== 1'(curPort))
          $display("FAIL rand_grant t%0d: got %b want %0d", it, grant[1], curPort);
        else nPass++;
      end
      nTotal++;
      if (memAddr[1] !== (inAcc ? cAddr : 16'h0000) || ((!inAcc || cWE) && memWrite[1] !== (inAcc ? cWData : 16'h0000)))
        $display("FAIL rand_bus t%0d: addr %h data %h want %h", it, memAddr[1], memWrite[1], inAcc ? cAddr : 16'h0000);
      else nPass++;
      nTotal++;
      if (p0RData[1] !== expR0 || p1RData[1] !== expR1)
        $display("FAIL rand_rdata t%0d: %h %h want %h %h", it, p0RData[1], p1RData[1], expR0, expR1);
      else nPass++;
      lastR[0] = expR0;
      lastR[1] = expR1;
      if (ackNow) req[curPort] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p]   = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = 16'($urandom);
          wdata[p] = 16'($urandom);
        end
      end
      p0Req = req[0]; p0WE = we[0]; p0Addr = addr[0]; p0WData = wdata[0];
      p1Req = req[1]; p1WE = we[1]; p1Addr = addr[1]; p1WData = wdata[1];
      if (!act || ackNow) begin
        e0  = req[0] && !(ackNow && curPort == 0);
        e1  = req[1] && !(ackNow && curPort == 1);
        act = e0 || e1;
        if (act) begin
          curPort = (e0 && e1) ? 1 - lastG : (e1 ? 1 : 0);
          lastG   = curPort;
          cWE     = we[curPort];
          cAddr   = addr[curPort];
          cWData  = wdata[curPort];
          gEdge   = it;
          curEnd  = it + (cWE ? 2 : 3);
        end
      end
      @(negedge clk);
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_lat_sweep();
    test_dropped_req();
    test_random();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the single shared memory bus. It sits between the memory and two bus masters: port 0 for the CPU-side fetch/data path, and port 1 for a second master such as a DMA or loader. The block latches one request at a time, drives `memAddr`/`memWrite`/`memWE`, waits out the memory read latency and returns read data with a one-cycle acknowledge.

## Interface
- `M`, 16, bus width (address and data).
- `LAT`, 1, memory read latency in cycles, from address valid to `memRead` valid; legal range 0..7.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `p0Req`  in  1  port 0 request; held until `p0Ack`.
- `p0WE`  in  1  port 0 write (1) / read (0).
- `p0Addr`  in  M  port 0 address.
- `p0WData`  in  M  port 0 write data.
- `p0Ack`  out  1  port 0 one-cycle completion pulse.
- `p0RData`  out  M  port 0 read data; valid while `p0Ack`=1, held until the next port 0 read completes.
- `p1Req`, `p1WE`, `p1Addr`, `p1WData`, `p1Ack`, `p1RData`: same as port 0, for port 1.
- `memAddr`  out  M  memory address.
- `memWrite`  out  M  memory write data.
- `memWE`  out  1  memory write enable.
- `memRead`  in  M  memory read data.
- `grant`  out  1  port owning the current access; valid while `busy`=1.
- `busy`  out  1  state is not IDLE.

## Operation
- State machine has three states: IDLE, ACCESS, ACK.
- **Arbitration.** Arbitration runs in IDLE and ACK.
  - Eligible ports are those with Req=1. In ACK, the port being acknowledged is excluded.
  - Exactly one eligible port: grant it.
  - Both eligible: grant the port not equal to `lastGnt` (round-robin).
- **On grant.** Latch the port's addr, wdata and we into internal registers, set `grant` and `lastGnt` to the port number, load the latency counter, and go to ACCESS.
- **ACCESS, write.** Stays exactly 1 cycle, with `memWE`=1, `memAddr`=latched address and `memWrite`=latched data. Then go to ACK.
- **ACCESS, read.** Stays LAT+1 cycles with `memAddr`=latched address and `memWE`=0. On the last ACCESS cycle, capture `memRead` into the granted port's RData register. Then go to ACK.
- **ACK.** Stays 1 cycle with Ack of the granted port = 1.
  - If arbitration finds an eligible port, go straight to ACCESS (back-to-back).
  - Otherwise go to IDLE.
- **Outside ACCESS.** `memWE`=0 and `memAddr`/`memWrite` = 0.
- Request inputs are sampled only at grant. Changes to addr, wdata or we during ACCESS have no effect.
- If Req drops mid-transaction (a protocol violation), the transaction still completes and Ack is still issued.
- Only the granted port's RData register updates, and only on reads. The other RData register holds its value.
- **Reset (asynchronous, `rst`=0).** Takes effect immediately, including mid-transaction.
  - State = IDLE; `lastGnt` = 1, so port 0 wins the first tie.
  - `grant`=0, `busy`=0, `p0Ack`=`p1Ack`=0, `memWE`=0.
  - `memAddr`=`memWrite`=0, `p0RData`=`p1RData`=0.
  - Latency counter = 0.
  - An interrupted transaction is dropped with no Ack.

## Timing
- Cycle numbers are relative to the edge at which Req is sampled in IDLE (edge 0).
- Write: `memWE` is high during cycle 1 and Ack is high during cycle 2. Latency is 2 cycles.
- Read: `memAddr` is valid during cycles 1..LAT+1, `memRead` is captured at edge LAT+1, and Ack/RData are valid during cycle LAT+2. Latency is LAT+2.
- Back-to-back grant from ACK: the next ACCESS starts the cycle after ACK, with no IDLE cycle. The port that was just acknowledged always passes through IDLE or waits for the other port, so a continuously requesting port cannot lock out the other.
- `memAddr`, `memWrite`, `memWE`, Ack, RData, `grant` and `busy` are all registered outputs, with no combinational paths from inputs.
- Worst-case wait for a requesting port is one full transaction of the other port plus its own transaction.

## Test plan
- **Reset values.** Assert `rst`=0 mid-read (LAT=1, port 1 in ACCESS) → all outputs 0 in the same cycle; after release, no `p1Ack` is issued.
- **Single read, LAT=1.** `p0Req`=1, `p0WE`=0, `p0Addr`=0x0010, memory returns 0xBEEF → `memAddr`=0x0010 for cycles 1-2, `p0Ack`=1 in cycle 3 with `p0RData`=0xBEEF, `p1RData` unchanged.
- **Single write.** `p1Req`=1, `p1WE`=1, `p1Addr`=0x0200, `p1WData`=0x1234 → `memWE`=1 with those values only in cycle 1, `p1Ack` in cycle 2, `grant`=1.
- **Simultaneous requests after reset.** Both ports issue reads → port 0 is granted first. In port 0's ACK cycle, port 1 is granted with no IDLE cycle. Port 0 (still requesting) is served next, giving strict alternation 0,1,0,1 over 4 transactions.
- **LAT sweep.** LAT=0 and LAT=3 reads → Ack in cycles 2 and 5 respectively, with correct data. Changing `p0Addr` to 0xFFFF during ACCESS does not change `memAddr`.
- **Dropped request.** `p0Req` is deasserted in cycle 1 of a write → the write still hits memory and `p0Ack` still pulses in cycle 2.
